// File: rtl/dec_nx_seq.sv
// Registered N-to-2^N select generator: one-hot decode, thermometer, clear and
// a self-running one-hot scan from a start index to an end index.
module dec_nx_seq #(
    parameter int unsigned N    = 4,
    parameter int unsigned STEP = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in,
    input  logic [N-1:0]        lim,
    output logic [(2**N)-1:0]   out,
    output logic                out_valid,
    output logic                busy,
    output logic                done
);

    localparam int unsigned OUT_W = 2**N;
    localparam int unsigned SW    = (STEP > 1) ? $clog2(STEP) : 1;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    typedef enum logic [1:0] {
        M_DECODE = 2'b00,
        M_THERM  = 2'b01,
        M_SCAN   = 2'b10,
        M_CLEAR  = 2'b11
    } mode_t;

    state_t            r_state, w_state_nxt;
    logic [N-1:0]      r_cur, w_cur_nxt;
    logic [N-1:0]      r_lim, w_lim_nxt;
    logic [SW-1:0]     r_step, w_step_nxt;
    logic [OUT_W-1:0]  r_out, w_out_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic              r_done, w_done_nxt;
    logic              w_accept;
    logic [N-1:0]      w_cur_inc;

    function automatic logic [OUT_W-1:0] f_onehot(input logic [N-1:0] idx);
        return OUT_W'(1) << idx;
    endfunction

    // One extra bit so that idx = 2^N-1 yields all ones after the subtract.
    function automatic logic [OUT_W-1:0] f_therm(input logic [N-1:0] idx);
        logic [OUT_W:0] t;
        t = ((OUT_W + 1)'(2) << idx) - (OUT_W + 1)'(1);
        return t[OUT_W-1:0];
    endfunction

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_cur_inc = r_cur + N'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_nxt       = r_cur;
        w_lim_nxt       = r_lim;
        w_step_nxt      = r_step;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_out_valid_nxt = 1'b1;
                    case (mode_t'(mode))
                        M_DECODE: w_out_nxt = en ? f_onehot(in) : '0;
                        M_THERM:  w_out_nxt = en ? f_therm(in) : '0;
                        M_CLEAR:  w_out_nxt = '0;
                        M_SCAN: begin
                            if (en) begin
                                w_cur_nxt   = in;
                                w_lim_nxt   = lim;
                                w_step_nxt  = '0;
                                w_out_nxt   = f_onehot(in);
                                w_done_nxt  = (in == lim);
                                w_state_nxt = S_SCAN;
                            end else begin
                                w_out_nxt = '0;
                            end
                        end
                        default: w_out_nxt = '0;
                    endcase
                end
            end

            S_SCAN: begin
                if (!en) begin
                    // Abort: blank the bus and return without a done pulse.
                    w_out_nxt       = '0;
                    w_out_valid_nxt = 1'b1;
                    w_step_nxt      = '0;
                    w_state_nxt     = S_IDLE;
                end else if (r_step == SW'(STEP - 1)) begin
                    w_step_nxt = '0;
                    if (r_cur == r_lim) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cur_nxt       = w_cur_inc;
                        w_out_nxt       = f_onehot(w_cur_inc);
                        w_out_valid_nxt = 1'b1;
                        w_done_nxt      = (w_cur_inc == r_lim);
                    end
                end else begin
                    w_step_nxt = r_step + SW'(1);
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cur       <= '0;
            r_lim       <= '0;
            r_step      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cur       <= w_cur_nxt;
            r_lim       <= w_lim_nxt;
            r_step      <= w_step_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign done      = r_done;
    assign busy      = (r_state == S_SCAN);
    assign in_ready  = (r_state == S_IDLE);

endmodule

// File: doc/dec_nx_seq.md
Name: dec_nx_seq

Overview:
Parametrised, registered N-to-2^N decoder with enable, command handshake and four modes: one-hot decode, thermometer, auto-scan (walking one) and clear. Generalises the combinational 4-to-16 decoder into a clocked select generator. It drives chip-select, mux-select or LED-bank style one-hot/thermometer buses. Scan mode sweeps a one-hot index range on its own, so the controller issues one command per sweep.

Parameters:
N, 4, select width; output width OUT_W = 2**N
STEP, 1, clock cycles each scan value is held (must be >= 1)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
en  input  1  output enable, sampled with the command and continuously during scan
mode  input  2  00 DECODE, 01 THERM, 10 SCAN, 11 CLEAR; sampled on accept
in_valid  input  1  command valid
in_ready  output  1  command ready; equals !busy
in  input  N  index (DECODE/THERM) or scan start index (SCAN)
lim  input  N  scan end index, sampled on accept
out  output  OUT_W  registered decoded bus
out_valid  output  1  one-cycle pulse on every update of out
busy  output  1  high while in SCAN state
done  output  1  one-cycle pulse with the final scan value

Behaviour:
- Reset (rstn low, asynchronous): out=0, out_valid=0, busy=0, done=0, state IDLE, internal index and step counter = 0. Takes effect immediately, including mid-scan.
- States: IDLE and SCAN. in_ready = !busy. A command is accepted when in_valid && in_ready at a rising edge. in_valid while busy is ignored and not queued.
- Latency: 1 cycle. out and out_valid update on the edge after the accepting edge.
- DECODE: out = en ? (1 << in) : 0. out_valid pulses. Stay IDLE.
- THERM: out = en ? bits [in:0] set : 0. Compute as ((2 << in) - 1) in OUT_W+1 bits, then truncate. in = 2^N-1 gives all ones. Stay IDLE.
- CLEAR: out = 0. out_valid pulses. en is ignored. Stay IDLE.
- SCAN with en=0 at accept: treated as CLEAR; no SCAN entry and no done.
- SCAN with en=1 at accept:
  - cur = in; out = 1 << in; out_valid=1; busy=1; enter SCAN.
  - Each value is held STEP cycles. Then cur = (cur+1) mod 2^N, out = 1 << cur, out_valid pulses.
  - The value equal to lim is the last one. done pulses in the same cycle out shows 1 << lim.
  - That value is held STEP cycles, then busy=0 and the state returns to IDLE. out keeps 1 << lim.
  - Values presented = ((lim - in) mod 2^N) + 1. lim < in wraps through 2^N-1 to 0. in == lim presents one value, with done asserted together with it.
- en falling during SCAN: on the next edge out=0, out_valid pulses, busy=0, state IDLE, done not asserted (abort).
- Outside SCAN, out holds its last value until the next accepted command. en changes alone do not alter out.
- Simultaneous final-step and in_valid: the command is not accepted until in_ready is high. Earliest accept is the cycle busy drops.

Test Plan:
- Reset, then DECODE with en=1, in=4'h5 -> one cycle later out=16'h0020, out_valid pulses once, busy=0.
- THERM with in=3 -> out=16'h000F. THERM with in=15 -> out=16'hFFFF. THERM with en=0 -> out=0.
- SCAN with in=14, lim=1, STEP=1 -> out sequence 4000, 8000, 0001, 0002 on consecutive cycles. done coincides with 0002. busy high 4 cycles. in_valid during busy is ignored.
- SCAN with in=lim=7, STEP=2 -> out=0080 held 2 cycles, done in the first of them, in_ready returns high after 2 cycles.
- SCAN with in=0, lim=15, en dropped after the 3rd value -> out=0 next cycle, done never pulses, in_ready=1.
- rstn pulsed low mid-scan, asynchronous to clk -> out=0, busy=0, done=0 immediately. Next DECODE with in=0 gives out=0001.
